ring_bridge_drain_arbiter: RTL and testbench

- Shares one global-ring output slot among NREQ connect-router bridge buffers, with at most one flit drained per cycle.
- Sits between the connect routers' buffer ports (head flit, size, pop) and the global-ring register stage.
- Each cycle, a flit is inserted only when the incoming global-ring slot is empty.
- Arbitration is round-robin, with urgent override for full or starved buffers.

---
 rtl/ring_bridge_drain_arbiter_if.sv | 26 ++
 rtl/ring_bridge_drain_arbiter.sv | 123 ++++++++++++
 tb/tb_ring_bridge_drain_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/ring_bridge_drain_arbiter_if.sv
// Bus between the connect-router bridge buffers, the global-ring register stage
// and the drain arbiter that shares the ring output slot among them.
interface ring_bridge_drain_arbiter_if #(
   parameter int NREQ   = 4,
   parameter int CTRL_W = 8
);
   logic [CTRL_W-1:0]      ring_in;
   logic                   en;
   logic [3*NREQ-1:0]      buf_size;
   logic [CTRL_W*NREQ-1:0] buf_head;
   logic [NREQ-1:0]        pop;
   logic [CTRL_W-1:0]      ring_out;
   logic [2:0]             grant_id;
   logic                   grant_vld;
   logic                   starve_evt;

   modport master (
      output ring_in, en, buf_size, buf_head,
      input  pop, ring_out, grant_id, grant_vld, starve_evt
   );

   modport slave (
      input  ring_in, en, buf_size, buf_head,
      output pop, ring_out, grant_id, grant_vld, starve_evt
   );
endinterface

// File: rtl/ring_bridge_drain_arbiter.sv
// Drains at most one bridge-buffer head flit per cycle into a free global-ring slot,
// round-robin with an urgent override for full (size 7) or starved requesters.
module ring_bridge_drain_arbiter #(
   parameter int NREQ       = 4,
   parameter int STARVE_LIM = 6,
   parameter int CTRL_W     = 8,
   parameter int VALID_F    = 7
) (
   input logic                          clk,
   input logic                          rst,
   ring_bridge_drain_arbiter_if.slave   bus
);
   localparam logic [3:0] LIM    = 4'(STARVE_LIM);
   localparam logic [3:0] LIM_M1 = 4'(STARVE_LIM - 1);
   localparam logic [3:0] NREQ_W = 4'(NREQ);
   localparam logic [2:0] LAST   = 3'(NREQ - 1);

   logic [CTRL_W-1:0] r_ring_out;
   logic [2:0]        r_grant_id;
   logic [2:0]        r_rr_ptr;
   logic              r_grant_vld;
   logic              r_starve_evt;
   logic [3:0]        r_wait [NREQ];

   logic [7:0]        w_req;
   logic [7:0]        w_urg;
   logic [CTRL_W-1:0] w_head [8];
   logic [2:0]        w_sz;
   logic [3:0]        w_sum;
   logic [2:0]        w_idx;
   logic [2:0]        w_urg_sel;
   logic [2:0]        w_req_sel;
   logic              w_urg_hit;
   logic              w_req_hit;
   logic [2:0]        w_sel;
   logic [2:0]        w_next_ptr;
   logic              w_grant;
   logic              w_starve;
   logic [NREQ-1:0]   w_pop;
   logic [3:0]        w_wait_nxt [NREQ];

   // Unpack per-requester size/head; derive request and urgency flags.
   always_comb begin
      w_req = 8'h00;
      w_urg = 8'h00;
      w_sz  = 3'd0;
      for (int i = 0; i < 8; i++) begin
         w_head[i] = {CTRL_W{1'b0}};
      end
      for (int i = 0; i < NREQ; i++) begin
         w_sz      = bus.buf_size[3*i +: 3];
         w_head[i] = bus.buf_head[CTRL_W*i +: CTRL_W];
         w_req[i]  = (w_sz != 3'd0);
         w_urg[i]  = w_req[i] && ((w_sz == 3'd7) || (r_wait[i] >= LIM));
      end
   end

   // Cyclic search from rr_ptr; walking backwards lets the nearest hit win last.
   always_comb begin
      w_urg_hit = 1'b0;
      w_req_hit = 1'b0;
      w_urg_sel = 3'd0;
      w_req_sel = 3'd0;
      w_sum     = 4'd0;
      w_idx     = 3'd0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         w_sum     = {1'b0, r_rr_ptr} + 4'(k);
         w_idx     = (w_sum >= NREQ_W) ? 3'(w_sum - NREQ_W) : w_sum[2:0];
         w_urg_sel = w_urg[w_idx] ? w_idx : w_urg_sel;
         w_req_sel = w_req[w_idx] ? w_idx : w_req_sel;
         w_urg_hit = w_urg_hit | w_urg[w_idx];
         w_req_hit = w_req_hit | w_req[w_idx];
      end
   end

   // Grant qualification, one-hot pop and next wait-counter values.
   always_comb begin
      w_sel      = w_urg_hit ? w_urg_sel : w_req_sel;
      w_grant    = bus.en && !rst && !bus.ring_in[VALID_F] && w_req_hit;
      w_next_ptr = (w_sel == LAST) ? 3'd0 : (w_sel + 3'd1);
      w_starve   = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         w_pop[i]      = w_grant && (w_sel == 3'(i));
         w_wait_nxt[i] = (!w_req[i] || w_pop[i]) ? 4'd0 :
                         ((r_wait[i] == 4'd15) ? 4'd15 : (r_wait[i] + 4'd1));
         w_starve      = w_starve | (w_req[i] && !w_pop[i] && (r_wait[i] == LIM_M1));
      end
   end

   // Ring register stage, grant reporting, round-robin pointer and wait counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ring_out   <= {CTRL_W{1'b0}};
         r_grant_id   <= 3'd0;
         r_grant_vld  <= 1'b0;
         r_starve_evt <= 1'b0;
         r_rr_ptr     <= 3'd0;
         for (int i = 0; i < NREQ; i++) begin
            r_wait[i] <= 4'd0;
         end
      end else begin
         if (w_grant) begin
            r_ring_out  <= w_head[w_sel];
            r_grant_id  <= w_sel;
            r_grant_vld <= 1'b1;
            r_rr_ptr    <= w_next_ptr;
         end else begin
            r_ring_out  <= bus.ring_in;
            r_grant_vld <= 1'b0;
         end
         r_starve_evt <= w_starve;
         for (int i = 0; i < NREQ; i++) begin
            r_wait[i] <= w_wait_nxt[i];
         end
      end
   end

   assign bus.pop        = w_pop;
   assign bus.ring_out   = r_ring_out;
   assign bus.grant_id   = r_grant_id;
   assign bus.grant_vld  = r_grant_vld;
   assign bus.starve_evt = r_starve_evt;
endmodule

// File: tb/tb_ring_bridge_drain_arbiter.sv
// Self-checking bench: vector table plus hand-written reset/enable sequences,
// with registered expectations queued at drive time and checked after the edge.
module tb_ring_bridge_drain_arbiter;
   localparam int NREQ   = 4;
   localparam int CTRL_W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   ring_bridge_drain_arbiter_if #(.NREQ(NREQ), .CTRL_W(CTRL_W)) bus ();

   ring_bridge_drain_arbiter #(
      .NREQ(NREQ), .STARVE_LIM(6), .CTRL_W(CTRL_W), .VALID_F(7)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  ring_in;
      logic        en;
      logic [11:0] size;
      logic [3:0]  pop;
      logic [7:0]  ring_out;
      logic [2:0]  gid;
      logic        gvld;
      logic        starve;
   } vec_t;

   typedef struct {
      logic [7:0] ring_out;
      logic [2:0] gid;
      logic       gvld;
      logic       starve;
   } exp_t;

   localparam logic [11:0] ALL2 = {3'd2, 3'd2, 3'd2, 3'd2};

   exp_t sb[$];
   vec_t tbl[19];

   function automatic vec_t mk(input logic [7:0] ri, input logic en, input logic [11:0] sz,
                               input logic [3:0] pp, input logic [7:0] ro, input logic [2:0] gid,
                               input logic gv, input logic st);
      vec_t v;
      v.ring_in = ri; v.en = en; v.size = sz; v.pop = pp;
      v.ring_out = ro; v.gid = gid; v.gvld = gv; v.starve = st;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, req);
      end
   endtask

   task automatic step(input vec_t v, input string nm);
      exp_t e;
      exp_t got;
      @(negedge clk);
      bus.ring_in  = v.ring_in;
      bus.en       = v.en;
      bus.buf_size = v.size;
      #1;
      chk({nm, " pop"}, 32'(bus.pop), 32'(v.pop));
      e.ring_out = v.ring_out; e.gid = v.gid; e.gvld = v.gvld; e.starve = v.starve;
      sb.push_back(e);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      chk({nm, " ring_out"},   32'(bus.ring_out),   32'(got.ring_out));
      chk({nm, " grant_id"},   32'(bus.grant_id),   32'(got.gid));
      chk({nm, " grant_vld"},  32'(bus.grant_vld),  32'(got.gvld));
      chk({nm, " starve_evt"}, 32'(bus.starve_evt), 32'(got.starve));
   endtask

   task automatic reset_dut();
      @(negedge clk);
      bus.buf_size = 12'h000;
      bus.ring_in  = 8'h00;
      rst = 1'b1;
      #2;
      rst = 1'b0;
   endtask

   initial begin
      bus.ring_in  = 8'h00;
      bus.en       = 1'b1;
      bus.buf_size = ALL2;
      bus.buf_head = {8'hC0, 8'hB0, 8'hA0, 8'h90};

      tbl[0]  = mk(8'h85, 1'b1, 12'h000, 4'b0000, 8'h85, 3'd0, 1'b0, 1'b0);
      tbl[1]  = mk(8'h86, 1'b1, 12'h000, 4'b0000, 8'h86, 3'd0, 1'b0, 1'b0);
      tbl[2]  = mk(8'h00, 1'b1, ALL2, 4'b0001, 8'h90, 3'd0, 1'b1, 1'b0);
      tbl[3]  = mk(8'h00, 1'b1, ALL2, 4'b0010, 8'hA0, 3'd1, 1'b1, 1'b0);
      tbl[4]  = mk(8'h00, 1'b1, ALL2, 4'b0100, 8'hB0, 3'd2, 1'b1, 1'b0);
      tbl[5]  = mk(8'h00, 1'b1, ALL2, 4'b1000, 8'hC0, 3'd3, 1'b1, 1'b0);
      tbl[6]  = mk(8'h00, 1'b1, ALL2, 4'b0001, 8'h90, 3'd0, 1'b1, 1'b0);
      tbl[7]  = mk(8'h00, 1'b1, {3'd0, 3'd0, 3'd2, 3'd0}, 4'b0010, 8'hA0, 3'd1, 1'b1, 1'b0);
      // rr_ptr is 2 here; full requester 1 beats plain requester 3
      tbl[8]  = mk(8'h00, 1'b1, {3'd2, 3'd0, 3'd7, 3'd0}, 4'b0010, 8'hA0, 3'd1, 1'b1, 1'b0);
      tbl[9]  = mk(8'h00, 1'b1, {3'd2, 3'd0, 3'd2, 3'd0}, 4'b1000, 8'hC0, 3'd3, 1'b1, 1'b0);
      tbl[10] = mk(8'h00, 1'b1, 12'h000, 4'b0000, 8'h00, 3'd3, 1'b0, 1'b0);
      tbl[11] = mk(8'h00, 1'b1, {3'd0, 3'd2, 3'd0, 3'd0}, 4'b0100, 8'hB0, 3'd2, 1'b1, 1'b0);
      for (int k = 0; k < 6; k++) begin
         tbl[12+k] = mk(8'(8'h85 + k), 1'b1, {3'd0, 3'd0, 3'd0, 3'd3}, 4'b0000,
                        8'(8'h85 + k), 3'd2, 1'b0, (k == 5));
      end
      tbl[18] = mk(8'h00, 1'b1, {3'd2, 3'd0, 3'd0, 3'd3}, 4'b0001, 8'h90, 3'd0, 1'b1, 1'b0);

      #12;
      chk("reset pop",        32'(bus.pop),        32'h0);
      chk("reset ring_out",   32'(bus.ring_out),   32'h0);
      chk("reset grant_id",   32'(bus.grant_id),   32'h0);
      chk("reset grant_vld",  32'(bus.grant_vld),  32'h0);
      chk("reset starve_evt", 32'(bus.starve_evt), 32'h0);
      bus.buf_size = 12'h000;
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 19; i++) begin
         step(tbl[i], $sformatf("row%0d", i));
      end

      // Drain disabled: pass-through, one starvation pulse, counters saturate
      reset_dut();
      for (int k = 0; k < 24; k++) begin
         step(mk(8'h03, 1'b0, ALL2, 4'b0000, 8'h03, 3'd0, 1'b0, (k == 5)),
              $sformatf("en0_c%0d", k));
      end
      step(mk(8'h00, 1'b1, ALL2, 4'b0001, 8'h90, 3'd0, 1'b1, 1'b0), "en1_after");

      // Reset asserted while grant_vld is high
      reset_dut();
      step(mk(8'h00, 1'b1, {3'd0, 3'd0, 3'd2, 3'd0}, 4'b0010, 8'hA0, 3'd1, 1'b1, 1'b0), "pre_rst");
      @(negedge clk);
      bus.buf_size = ALL2;
      bus.ring_in  = 8'h00;
      bus.en       = 1'b1;
      rst = 1'b1;
      #1;
      chk("midrst pop",        32'(bus.pop),        32'h0);
      chk("midrst ring_out",   32'(bus.ring_out),   32'h0);
      chk("midrst grant_id",   32'(bus.grant_id),   32'h0);
      chk("midrst grant_vld",  32'(bus.grant_vld),  32'h0);
      chk("midrst starve_evt", 32'(bus.starve_evt), 32'h0);
      #1;
      rst = 1'b0;
      #1;
      chk("postrst pop", 32'(bus.pop), 32'h1);
      @(posedge clk);
      #1;
      chk("postrst ring_out",  32'(bus.ring_out),  32'h90);
      chk("postrst grant_id",  32'(bus.grant_id),  32'h0);
      chk("postrst grant_vld", 32'(bus.grant_vld), 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
